udp_rx_pack_fifo: RTL



---
 rtl/udp_rx_pack_fifo_if.sv | 35 +++
 rtl/udp_rx_pack_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/udp_rx_pack_fifo_if.sv
// Handshake bundle between the UDP receive byte stream, the packing FIFO and its word consumer.
// slave = FIFO side, master = producer/consumer side.
interface udp_rx_pack_fifo_if #(
    parameter int IN_W   = 8,
    parameter int RATIO  = 2,
    parameter int ADDR_W = 9
);
    localparam int OUT_W = IN_W * RATIO;

    logic              wr_en;
    logic [IN_W-1:0]   wr_data;
    logic              wr_last;
    logic              wr_full;
    logic              wr_ovf;
    logic              rd_en;
    logic [OUT_W-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              rd_empty;
    logic [ADDR_W:0]   water_level;
    logic              almost_full;
    logic              almost_empty;

    modport slave (
        input  wr_en, wr_data, wr_last, rd_en,
        output wr_full, wr_ovf, rd_data, rd_valid, rd_last, rd_empty,
               water_level, almost_full, almost_empty
    );

    modport master (
        output wr_en, wr_data, wr_last, rd_en,
        input  wr_full, wr_ovf, rd_data, rd_valid, rd_last, rd_empty,
               water_level, almost_full, almost_empty
    );
endinterface

// File: rtl/udp_rx_pack_fifo.sv
// Packs IN_W-bit bytes into RATIO*IN_W-bit words (first byte in the MSB lane) and buffers them in a
// 2**ADDR_W-word FIFO with level flags. Define PACK_FIFO_FLUSH_EN to push zero-padded partial words on wr_last.
module udp_rx_pack_fifo #(
    parameter int IN_W   = 8,
    parameter int RATIO  = 2,
    parameter int ADDR_W = 9,
    parameter int AF_LVL = (2**ADDR_W) - 4,
    parameter int AE_LVL = 4
) (
    input  logic               sys_clk,
    input  logic               rst,
    udp_rx_pack_fifo_if.slave  fifo_bus
);
    localparam int OUT_W  = IN_W * RATIO;
    localparam int DEPTH  = 2**ADDR_W;
    localparam int LANE_W = $clog2(RATIO);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [ADDR_W:0]   FULL_LVL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C      = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0]   AE_C      = (ADDR_W+1)'(AE_LVL);

    // ---------------- packer ----------------
    logic [LANE_W-1:0] r_lane;
    logic [RATIO-1:0]  r_fill;
    logic [OUT_W-1:0]  w_word;
    logic              w_lane_done;
    logic              w_push_req;
    logic              w_push_last;

    assign w_lane_done = fifo_bus.wr_en && (r_lane == LAST_LANE);

`ifdef PACK_FIFO_FLUSH_EN
    logic w_flush;
    assign w_flush     = fifo_bus.wr_last && (fifo_bus.wr_en || (r_lane != '0));
    assign w_push_req  = w_lane_done || w_flush;
    assign w_push_last = fifo_bus.wr_last;
`else
    assign w_push_req  = w_lane_done;
    assign w_push_last = 1'b0;
`endif

    // r_fill marks lanes holding a byte of the current word; unfilled lanes read as zero padding.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            localparam int HI = OUT_W - 1 - gi * IN_W;
            logic            w_hit;
            logic [IN_W-1:0] r_byte;

            assign w_hit = fifo_bus.wr_en && (r_lane == LANE_W'(gi));

            always_ff @(posedge sys_clk) begin
                if (w_hit) begin
                    r_byte <= fifo_bus.wr_data;
                end
            end

            always_ff @(posedge sys_clk) begin
                if (rst || w_push_req) begin
                    r_fill[gi] <= 1'b0;
                end else if (w_hit) begin
                    r_fill[gi] <= 1'b1;
                end
            end

            assign w_word[HI -: IN_W] = w_hit      ? fifo_bus.wr_data :
                                        r_fill[gi] ? r_byte           : '0;
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_lane <= '0;
        end else if (w_push_req) begin
            r_lane <= '0;
        end else if (fifo_bus.wr_en) begin
            r_lane <= r_lane + LANE_W'(1);
        end
    end

    // ---------------- FIFO core ----------------
    logic [OUT_W:0]    r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [ADDR_W:0]   w_level_next;
    logic [OUT_W:0]    r_rd_word;
    logic              r_rd_valid;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_ovf;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = fifo_bus.rd_en && !r_empty;
    // When full, a pop in the same cycle frees the slot the new word lands in.
    assign w_push = w_push_req && (!r_full || w_pop);

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_push_last, w_word};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_rd_word <= '0;
        end else if (w_pop) begin
            r_rd_word <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + (ADDR_W+1)'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - (ADDR_W+1)'(1);
        end
    end

    // Flags are registered from the next level so they move together with water_level.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_level <= w_level_next;
            r_full  <= (w_level_next == FULL_LVL);
            r_empty <= (w_level_next == '0);
            r_af    <= (w_level_next >= AF_C);
            r_ae    <= (w_level_next <= AE_C);
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign fifo_bus.wr_full      = r_full;
    assign fifo_bus.wr_ovf       = r_ovf;
    assign fifo_bus.rd_data      = r_rd_word[OUT_W-1:0];
    assign fifo_bus.rd_valid     = r_rd_valid;
    assign fifo_bus.rd_empty     = r_empty;
    assign fifo_bus.water_level  = r_level;
    assign fifo_bus.almost_full  = r_af;
    assign fifo_bus.almost_empty = r_ae;

`ifdef PACK_FIFO_FLUSH_EN
    assign fifo_bus.rd_last = r_rd_word[OUT_W];
`else
    logic [1:0] w_unused_last;
    assign w_unused_last    = {fifo_bus.wr_last, r_rd_word[OUT_W]};
    assign fifo_bus.rd_last = 1'b0;
`endif

endmodule
